// File: rtl/alu_op_decoder.sv
// alu_op_decoder: MIPS32 ALU-op decode into a one-entry ready/valid register stage toward EX.
// Optional seb/seh support is enabled by defining SEB_SEH_EN.
module alu_op_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  output logic        id_ready,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic        ex_use_imm,
  output logic        ex_imm_sext,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_ri
);
  logic [5:0]  op, fn;
  logic [4:0]  sa;
  logic [3:0]  dec_alu;
  logic        dec_imm, dec_sext, dec_wr, dec_ri;
  logic [4:0]  dec_rd;
  logic [12:0] dec_pl, payload_d, payload_q;
  logic        ex_valid_d, ex_valid_q, xfer;
  assign op = id_instr[31:26];
  assign fn = id_instr[5:0];
  assign sa = id_instr[10:6];
  always_comb begin
    dec_alu  = 4'h0;
    dec_imm  = 1'b0;
    dec_sext = 1'b0;
    dec_rd   = id_instr[15:11];
    dec_wr   = 1'b1;
    dec_ri   = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20: dec_alu = 4'he;
        6'h21: dec_alu = 4'h0;
        6'h22: dec_alu = 4'hf;
        6'h23: dec_alu = 4'h1;
        6'h24: dec_alu = 4'h4;
        6'h25: dec_alu = 4'h6;
        6'h26: dec_alu = 4'h9;
        6'h27: dec_alu = 4'h8;
        6'h2a: dec_alu = 4'h5;
        6'h2b: dec_alu = 4'h7;
        default: dec_ri = 1'b1;
      endcase
      6'h1c: begin
        dec_alu = fn == 6'h20 ? 4'h2 : 4'h3;
        dec_ri  = fn != 6'h20 && fn != 6'h21;
      end
`ifdef SEB_SEH_EN
      6'h1f: begin
        dec_alu = sa == 5'h10 ? 4'ha : 4'hb;
        dec_ri  = fn != 6'h20 || (sa != 5'h10 && sa != 5'h18);
      end
`endif
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b: begin
        dec_imm  = 1'b1;
        dec_rd   = id_instr[20:16];
        dec_sext = op[3:2] != 2'b11;
        dec_wr   = op != 6'h2b;
        dec_alu  = op == 6'h08 ? 4'he : op == 6'h0a ? 4'h5 : op == 6'h0b ? 4'h7 :
                   op == 6'h0c ? 4'h4 : op == 6'h0d ? 4'h6 : op == 6'h0e ? 4'h9 : 4'h0;
      end
      default: dec_ri = 1'b1;
    endcase
    // Reserved encodings collapse to a harmless no-write addu with a zero destination.
    if (dec_ri) begin
      dec_alu  = 4'h0;
      dec_imm  = 1'b0;
      dec_sext = 1'b0;
      dec_rd   = 5'd0;
      dec_wr   = 1'b0;
    end
    if (dec_rd == 5'd0) dec_wr = 1'b0;
  end
  assign dec_pl   = {dec_ri, dec_wr, dec_rd, dec_sext, dec_imm, dec_alu};
  assign id_ready = !ex_valid_q || ex_ready;
  assign xfer     = id_valid && id_ready;
  always_comb begin
    ex_valid_d = flush ? 1'b0 : xfer ? 1'b1 : ex_ready ? 1'b0 : ex_valid_q;
    payload_d  = xfer && !flush ? dec_pl : payload_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      payload_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      payload_q  <= payload_d;
    end
  assign ex_valid = ex_valid_q;
  assign {ex_ri, ex_reg_write, ex_rd, ex_imm_sext, ex_use_imm, ex_alu_op} = payload_q;
endmodule

// File: tb/tb_alu_op_decoder.sv
// tb_alu_op_decoder: table-driven reference model with per-cycle compare plus directed literal checks.
module tb_alu_op_decoder;
  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, ex_ready = 1'b0, flush = 1'b0;
  logic [31:0] id_instr = '0;
  logic id_ready, ex_valid, ex_use_imm, ex_imm_sext, ex_reg_write, ex_ri;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_rd;
  int checks = 0, errors = 0;

  alu_op_decoder dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_ready(id_ready),
    .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_use_imm(ex_use_imm), .ex_imm_sext(ex_imm_sext), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_ri(ex_ri)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] R_FN [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
  localparam logic [3:0] R_OP [10] = '{4'he, 4'h0, 4'hf, 4'h1, 4'h4, 4'h6, 4'h9, 4'h8, 4'h5, 4'h7};
  localparam logic [5:0] I_OPC [9] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b};
  localparam logic [3:0] I_ALU [9] = '{4'he, 4'h0, 4'h5, 4'h7, 4'h4, 4'h6, 4'h9, 4'h0, 4'h0};
  localparam logic       I_SX  [9] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};

  // Returns {ri, reg_write, rd, imm_sext, use_imm, alu_op}.
  function automatic logic [12:0] model(input logic [31:0] i);
    logic [5:0] o = i[31:26], f = i[5:0];
    logic [3:0] a = 4'h0;
    logic hit = 1'b0, imm = 1'b0, sx = 1'b0, wr = 1'b1;
    logic [4:0] rd = i[15:11];
    if (o == 6'h00)
      for (int k = 0; k < 10; k++) if (f == R_FN[k]) begin hit = 1'b1; a = R_OP[k]; end
    if (o == 6'h1c && (f == 6'h20 || f == 6'h21)) begin hit = 1'b1; a = f == 6'h20 ? 4'h2 : 4'h3; end
`ifdef SEB_SEH_EN
    if (o == 6'h1f && f == 6'h20 && i[10:6] == 5'h10) begin hit = 1'b1; a = 4'ha; end
    if (o == 6'h1f && f == 6'h20 && i[10:6] == 5'h18) begin hit = 1'b1; a = 4'hb; end
`endif
    for (int k = 0; k < 9; k++)
      if (o == I_OPC[k]) begin
        hit = 1'b1; a = I_ALU[k]; imm = 1'b1; sx = I_SX[k]; rd = i[20:16]; wr = o != 6'h2b;
      end
    if (!hit) return {1'b1, 12'h0};
    return {1'b0, wr && rd != 0, rd, sx, imm, a};
  endfunction

  logic m_valid = 1'b0;
  logic [12:0] m_pl = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pl    <= '0;
    end else if (flush) m_valid <= 1'b0;
    else if (id_valid && (!m_valid || ex_ready)) begin
      m_valid <= 1'b1;
      m_pl    <= model(id_instr);
    end else if (ex_ready) m_valid <= 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  wire [12:0] dut_pl = {ex_ri, ex_reg_write, ex_rd, ex_imm_sext, ex_use_imm, ex_alu_op};

  always @(negedge clk) begin
    chk("model_valid", {31'b0, ex_valid}, {31'b0, m_valid});
    chk("model_payload", {19'b0, dut_pl}, {19'b0, m_pl});
    chk("model_id_ready", {31'b0, id_ready}, {31'b0, !m_valid || ex_ready});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    id_valid = 1'b1; id_instr = ins; ex_ready = 1'b1;
    step();
    id_valid = 1'b0;
  endtask

  localparam logic [31:0] VEC [14] = '{
    32'h00221822, 32'h00221824, 32'h00221827, 32'h0022182b, 32'h0022182a, 32'h00221826,
    32'h70201020, 32'h70201021, 32'h00220021, 32'h24000005, 32'h00000008, 32'h38a51234,
    32'h7c011620, 32'h7c011820};

  initial begin
    step();
    chk("reset_valid", {31'b0, ex_valid}, 32'd0);
    chk("reset_payload", {19'b0, dut_pl}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send(32'h00221821);
    chk("addu_valid", {31'b0, ex_valid}, 32'd1);
    chk("addu", {19'b0, dut_pl}, {19'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 4'h0});
    send(32'h3405ffff);
    chk("ori", {19'b0, dut_pl}, {19'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 4'h6});
    send(32'h28a5ffff);
    chk("slti", {19'b0, dut_pl}, {19'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 4'h5});
    send(32'hfc000000);
    chk("reserved", {19'b0, dut_pl}, {19'b0, 1'b1, 12'h0});
    send(32'h8c220004);
    chk("lw", {19'b0, dut_pl}, {19'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 4'h0});
    send(32'hac220004);
    chk("sw", {19'b0, dut_pl}, {19'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 4'h0});
    send(32'h7c011420);
`ifdef SEB_SEH_EN
    chk("seb", {19'b0, dut_pl}, {19'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 4'ha});
`else
    chk("seb_ri", {19'b0, dut_pl}, {19'b0, 1'b1, 12'h0});
`endif
    foreach (VEC[k]) send(VEC[k]);
    // Stall: A is held while B waits for three cycles.
    send(32'h00221821);
    id_valid = 1'b1; id_instr = 32'h00642022; ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_id_ready", {31'b0, id_ready}, 32'd0);
      chk("stall_hold", {19'b0, dut_pl}, {19'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 4'h0});
    end
    ex_ready = 1'b1;
    step();
    id_valid = 1'b0;
    chk("stall_release", {19'b0, dut_pl}, {19'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 4'hf});
    step();
    chk("drain_valid", {31'b0, ex_valid}, 32'd0);
    // Flush together with a transfer drops the instruction.
    send(32'h00221825);
    id_valid = 1'b1; id_instr = 32'h00221826; flush = 1'b1;
    step();
    flush = 1'b0; id_valid = 1'b0;
    chk("flush_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_hold", {19'b0, {1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 4'h6}}, {19'b0, dut_pl});
    send(32'h00221824);
    chk("post_flush", {19'b0, dut_pl}, {19'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 4'h4});
    // Asynchronous reset while a stalled instruction is held.
    id_valid = 1'b1; id_instr = 32'h3405ffff; ex_ready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("async_rst_payload", {19'b0, dut_pl}, 32'd0);
    id_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_id_ready", {31'b0, id_ready}, 32'd1);
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 id_valid  input  1  the ID stage presents an instruction.
REQ-005 id_instr  input  32  MIPS32 instruction word.
REQ-006 id_ready  output  1  the decoder accepts id_instr this cycle.
REQ-007 ex_ready  input  1  the EX stage accepts the registered decode this cycle.
REQ-008 flush  input  1  the registered decode is discarded (branch or exception).
REQ-009 ex_valid  output  1  the ex_* payload is valid.
REQ-010 ex_alu_op  output  4  4-bit ALU operation code.
REQ-011 ex_use_imm  output  1  operand B comes from the immediate.
REQ-012 ex_imm_sext  output  1  1 = sign-extend imm16, 0 = zero-extend imm16.
REQ-013 ex_rd  output  5  destination register number.
REQ-014 ex_reg_write  output  1  the instruction writes the register file.
REQ-015 ex_ri  output  1  reserved or unsupported instruction.

Function
REQ-016 alu_op encoding SHALL be: addu 0000, subu 0001, clz 0010, clo 0011, and 0100, slt 0101, or 0110, sltu 0111, nor 1000, xor 1001, seb 1010, seh 1011, add 1110, sub 1111.
REQ-017 Decode rules:
  - op=000000 (SPECIAL): funct 20/21/22/23/24/25/26/27/2A/2B (hex) SHALL map to add/addu/sub/subu/and/or/xor/nor/slt/sltu.
  - op=011100 (SPECIAL2): funct 20 SHALL map to clz; funct 21 SHALL map to clo.
  - Field usage: use_imm=0; rd=instr[15:11].
REQ-018 I-type decode: op 08/09/0A/0B SHALL map to add/addu/slt/sltu with imm_sext=1; op 0C/0D/0E SHALL map to and/or/xor with imm_sext=0; all I-type ops SHALL set use_imm=1 and rd=instr[20:16].
REQ-019 Loads and stores: lw (op 23) SHALL decode as addu, use_imm=1, imm_sext=1, rd=rt, reg_write=1; sw (op 2B) SHALL decode identically except reg_write=0.
REQ-020 Any other encoding SHALL produce ri=1, alu_op=0000, reg_write=0, use_imm=0, rd=0.
REQ-021 All ALU and I-type ops other than sw SHALL set reg_write=1; a destination of register 0 SHALL force reg_write=0.
REQ-022 Handshake: id_ready = !ex_valid | ex_ready (combinational); a transfer occurs when id_valid & id_ready.
REQ-023 Latency: the decode result SHALL appear on ex_* exactly one cycle after the transfer.
REQ-024 Update rules:
  - On a transfer the payload registers SHALL load the decode and ex_valid SHALL go to 1.
  - When ex_ready=1 and there is no transfer, ex_valid SHALL go to 0.
  - When ex_valid=1 and ex_ready=0, the payload and ex_valid SHALL hold.
REQ-025 flush SHALL have priority over everything else:
  - The next ex_valid SHALL be 0, even if a transfer occurs in the same cycle; the flushed instruction is dropped.
  - The payload registers SHALL hold their values.
REQ-026 id_ready SHALL NOT depend on flush or id_valid, so no combinational loop exists.

Reset
REQ-027 While rst_n=0 the outputs SHALL be: ex_valid=0, ex_alu_op=0000, ex_use_imm=0, ex_imm_sext=0, ex_rd=0, ex_reg_write=0, ex_ri=0; this holds immediately, with no clock needed.
REQ-028 A reset asserted mid-stall SHALL discard the held instruction; after release, id_ready=1.

Configuration
REQ-029 Macro SEB_SEH_EN:
  - When defined, op=011111, funct=100000 SHALL decode sa=10000 to seb and sa=11000 to seh, with use_imm=0, rd=instr[15:11], reg_write=1.
  - When undefined, these encodings SHALL decode as ri=1 per REQ-020.

Verification
REQ-030 addu $3,$1,$2 (0x00221821), id_valid=1, ex_ready=1 -> next cycle: ex_valid=1, alu_op=0000, rd=3, reg_write=1, use_imm=0.
REQ-031 ori $5,$0,0xFFFF (0x3405FFFF) -> alu_op=0110, use_imm=1, imm_sext=0, rd=5; then slti $5,$5,-1 (0x28A5FFFF) -> alu_op=0101, imm_sext=1.
REQ-032 Stall: hold ex_ready=0 for 3 cycles with id_valid=1 -> payload stable, id_ready=0; when ex_ready=1 the next instruction appears the following cycle, with no loss or duplication.
REQ-033 flush and a transfer in the same cycle -> next cycle ex_valid=0; a subsequent instruction decodes normally.
REQ-034 Instruction 0xFC000000 -> ex_ri=1, alu_op=0000, reg_write=0; seb $2,$1 (0x7C011420) -> alu_op=1010 with SEB_SEH_EN defined, ex_ri=1 without it.
REQ-035 Assert rst_n=0 asynchronously while ex_valid=1 under a stall -> all outputs at reset values before the next clock edge.
